// File: rtl/circular_queue.sv
// Circular FIFO with show-ahead read (zero-cycle read latency); enq_ready = ~full regardless of deq_ready.
// Define CIRCULAR_QUEUE_BYPASS_EN to let an empty queue pass enq_data straight to deq_data in the same cycle.
module circular_queue #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_data,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WIDTH-1:0]           deq_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             enq_fire;
  logic             deq_fire;
  logic             bypass_fire;
  logic             wr_en;
  logic             rd_en;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign almost_full = (count >= AFULL_CNT);
  assign enq_ready   = ~full;
  assign enq_fire    = enq_valid & enq_ready;
  assign deq_fire    = deq_valid & deq_ready;

`ifdef CIRCULAR_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass      = empty & enq_valid;
  assign deq_valid   = ~empty | bypass;
  assign deq_data    = bypass ? enq_data : mem[rd_ptr];
  assign bypass_fire = bypass & deq_ready;
`else
  assign deq_valid   = ~empty;
  assign deq_data    = mem[rd_ptr];
  assign bypass_fire = 1'b0;
`endif

  // A bypassed entry is consumed on the wire, so it never touches the array, pointers or count.
  assign wr_en = enq_fire & ~bypass_fire & ~flush;
  assign rd_en = deq_fire & ~bypass_fire & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= enq_data;
  end
endmodule

// File: tb/tb_circular_queue.sv
// Bench for circular_queue (DEPTH=5): directed scenarios plus random traffic against a queue-based reference model.
module tb_circular_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int AFT   = DEPTH - 2;
`ifdef CIRCULAR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_data = '0;
  logic             deq_valid;
  logic             deq_ready = 1'b0;
  logic [WIDTH-1:0] deq_data;
  logic [2:0]       count;
  logic             empty, full, almost_full;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deq    = 0;
  logic [WIDTH-1:0] mq[$];

  circular_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: samples between edges, compares to the model, then advances the model.
  initial begin
    int  ecnt;
    bit  byp, edv, efull;
    forever begin
      @(negedge clk);
      #2;
      if (rst) mq.delete();
      ecnt  = mq.size();
      efull = (ecnt == DEPTH);
      byp   = BYP && (ecnt == 0) && enq_valid;
      edv   = (ecnt != 0) || byp;
      chk("count",       32'(count),       32'(ecnt));
      chk("empty",       32'(empty),       32'(ecnt == 0));
      chk("full",        32'(full),        32'(efull));
      chk("almost_full", 32'(almost_full), 32'(ecnt >= AFT));
      chk("enq_ready",   32'(enq_ready),   32'(!efull));
      chk("deq_valid",   32'(deq_valid),   32'(edv));
      if (edv) chk("deq_data", deq_data, byp ? enq_data : mq[0]);
      if (edv && deq_ready && !rst) n_deq++;
      if (!rst) begin
        if (flush) mq.delete();
        else begin
          if (edv && deq_ready && !byp) void'(mq.pop_front());
          if (enq_valid && !efull && !(byp && deq_ready)) mq.push_back(enq_data);
        end
      end
    end
  end

  task automatic cyc(input bit ev, input logic [WIDTH-1:0] ed, input bit dr, input bit fl);
    @(negedge clk);
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    flush     = fl;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // fill and drain, including a dropped 6th enqueue
    for (int i = 0; i < 5; i++) cyc(1, 32'hA0 + 32'(i), 0, 0);
    cyc(1, 32'hA5, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    // wrap-around
    for (int i = 0; i < 3; i++) cyc(1, 32'h10 + 32'(i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 32'hB0 + 32'(i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    // simultaneous enq/deq at count=2, then at full
    for (int i = 0; i < 2; i++) cyc(1, 32'h20 + 32'(i), 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'h30 + 32'(i), 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h40 + 32'(i), 0, 0);
    cyc(1, 32'h99, 1, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    // flush with same-cycle enqueue of 0xCC
    for (int i = 0; i < 3; i++) cyc(1, 32'h50 + 32'(i), 0, 0);
    cyc(1, 32'hCC, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 32'h55, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    // asynchronous reset mid-cycle at count=4
    for (int i = 0; i < 4; i++) cyc(1, 32'h60 + 32'(i), 0, 0);
    cyc(0, 0, 0, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 32'hD0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    // empty-queue enqueue with deq_ready high
    cyc(1, 32'hEE, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
          $urandom_range(0, 39) == 0);
    cyc(0, 0, 1, 0);
    repeat (6) cyc(0, 0, 1, 0);
    @(negedge clk);
    #3;
    chk("deq_traffic_seen", 32'(n_deq >= 100), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/circular_queue.md
CIRCULAR_QUEUE -- requirements
Module: circular_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, 1 or more.
REQ-002 SHALL have parameter DEPTH, default 16: entry count, 2 or more, not required to be a power of two.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-2: occupancy at which almost_full asserts, 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port flush, input, 1 bit: synchronous clear of all entries.
REQ-007 SHALL have ports enq_valid (input, 1), enq_ready (output, 1) and enq_data (input, WIDTH): the write handshake.
REQ-008 SHALL have ports deq_valid (output, 1), deq_ready (input, 1) and deq_data (output, WIDTH): the read handshake.
REQ-009 SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-010 SHALL have ports empty, full and almost_full, each output, 1 bit: status flags.

Function
REQ-011 SHALL store entries in a DEPTH-entry array addressed by a write pointer and a read pointer; each pointer wraps from DEPTH-1 to 0 by explicit compare, not power-of-two modulo.
REQ-012 SHALL define enq fire as enq_valid & enq_ready, and deq fire as deq_valid & deq_ready.
REQ-013 SHALL drive enq_ready = ~full, independent of deq_ready, so no same-cycle enq is accepted while full.
REQ-014 SHALL drive deq_valid = ~empty and deq_data = array[read pointer] combinationally (show-ahead), with zero-cycle read latency.
REQ-015 SHALL, on enq fire, write enq_data at the write pointer and advance that pointer on the same edge.
REQ-016 SHALL, on deq fire, advance the read pointer; a written entry first appears on deq_data the cycle after its enq fire.
REQ-017 SHALL update count by +1 on enq fire only, -1 on deq fire only, and leave it unchanged on both or neither.
REQ-018 SHALL drive empty = (count==0), full = (count==DEPTH) and almost_full = (count >= AFULL_THRESH), all combinational from registered count.
REQ-019 SHALL ignore enq_valid while full and deq_ready while empty, with no state change; senders hold enq_data stable until fire.
REQ-020 SHALL, when flush=1 at an edge, zero both pointers and count, discard any same-cycle enq or deq fire, and give flush priority over all other activity.
REQ-021 SHALL leave array contents unreset and unflushed; deq_data is don't-care while deq_valid=0.

Reset
REQ-022 SHALL, on rst assertion and without waiting for clk, clear both pointers and count to 0, giving empty=1, full=0, almost_full=0, deq_valid=0 and enq_ready=1.
REQ-023 SHALL, on rst mid-transfer, drop all entries and any in-flight fire; the first post-reset enq lands at entry 0.
REQ-024 SHALL resume operation on the first clk edge after rst deassertion; the environment deasserts rst synchronously to clk.

Configuration
REQ-025 SHALL, with CIRCULAR_QUEUE_BYPASS_EN defined, present enq_data on deq_data with deq_valid=1 in the same cycle when empty=1 and enq_valid=1; if deq_ready=1 that cycle, the entry is neither written nor counted and count stays 0.
REQ-026 SHALL, with CIRCULAR_QUEUE_BYPASS_EN undefined, keep deq_valid=0 whenever empty=1 (minimum enq-to-deq latency one cycle).

Verification
REQ-027 SHALL test fill and drain with DEPTH=5, WIDTH=32: enqueue 0xA0..0xA4 -> full=1, count=5 and enq_ready=0; a 6th enq_valid is dropped; drain returns 0xA0..0xA4 in order, then empty=1.
REQ-028 SHALL test wrap-around with DEPTH=5: 3 enq, 3 deq, then 4 enq of 0xB0..0xB3 -> pointers wrap past index 4 and dequeue order is 0xB0..0xB3.
REQ-029 SHALL test simultaneous fire at count=2 with enq and deq together for 10 cycles -> count stays 2 and data order is preserved; at full with deq_ready=1 and enq_valid=1 -> only the deq fires and count=4.
REQ-030 SHALL test flush at count=3 with same-cycle enq fire of 0xCC -> next cycle count=0, empty=1, and 0xCC never appears on deq_data.
REQ-031 SHALL test async reset asserted mid-cycle at count=4 -> count=0 and empty=1 before the next clk edge; after deassertion, enq 0xD0 is dequeued as 0xD0.
REQ-032 SHALL test bypass with CIRCULAR_QUEUE_BYPASS_EN defined: empty, enq 0xEE with deq_ready=1 -> deq_data=0xEE the same cycle and count stays 0; when undefined, 0xEE appears the next cycle with count=1.
